// File: rtl/mem_blk_arbiter_if.sv
// Bundle of the I-cache, D-cache and main-memory block-transfer signals around mem_blk_arbiter.
// Handshake: a requester raises *_req with stable fields and holds it until it sees *_done,
// then drops it in that cycle; a memory strobe is held until its matching *_valid completes it.
interface mem_blk_arbiter_if #(
  parameter int BLK_W = 256
);
  logic             i_req;
  logic [31:0]      i_addr;
  logic [BLK_W-1:0] i_data;
  logic             i_done;

  logic             d_req;
  logic             d_wb;
  logic             d_rd;
  logic [31:0]      d_wb_addr;
  logic [BLK_W-1:0] d_wdata;
  logic [31:0]      d_addr;
  logic [BLK_W-1:0] d_rdata;
  logic             d_done;

  logic [31:0]      mem_addr;
  logic             mem_blk_read;
  logic             mem_blk_write;
  logic [BLK_W-1:0] mem_wdata;
  logic [BLK_W-1:0] mem_rdata;
  logic             mem_read_valid;
  logic             mem_write_valid;

  logic             busy;
  logic             timeout_err;

  modport slave (
    input  i_req, i_addr, d_req, d_wb, d_rd, d_wb_addr, d_wdata, d_addr,
           mem_rdata, mem_read_valid, mem_write_valid,
    output i_data, i_done, d_rdata, d_done, mem_addr, mem_blk_read, mem_blk_write,
           mem_wdata, busy, timeout_err
  );

  modport master (
    output i_req, i_addr, d_req, d_wb, d_rd, d_wb_addr, d_wdata, d_addr,
           mem_rdata, mem_read_valid, mem_write_valid,
    input  i_data, i_done, d_rdata, d_done, mem_addr, mem_blk_read, mem_blk_write,
           mem_wdata, busy, timeout_err
  );
endinterface

// File: rtl/mem_blk_arbiter.sv
// Round-robin owner of the main-memory block port: I-cache refills versus D-cache
// writeback+refill (issued as one atomic grant), with a retrying watchdog.
module mem_blk_arbiter #(
  parameter int BLK_W   = 256,
  parameter int TIMEOUT = 1023
) (
  input  logic                CLK,
  input  logic                RESET,
  mem_blk_arbiter_if.slave    bus,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IRD  = 2'd1,
    DWB  = 2'd2,
    DRD  = 2'd3
  } state_t;

  localparam int          CW        = $clog2(TIMEOUT + 1);
  localparam logic [31:0] BLK_MASK  = 32'hFFFF_FFE0;

  state_t           state, state_n;
  logic             last_served_d;
  logic [CW-1:0]    wd_cnt;
  logic             wd_drop;
  logic             timeout_err_q;

  logic [31:0]      i_addr_q, d_wb_addr_q, d_addr_q;
  logic             d_rd_q;
  logic [BLK_W-1:0] d_wdata_q;
  logic [BLK_W-1:0] i_data_q, d_rdata_q;
  logic             i_done_q, d_done_q;

  logic i_elig, d_elig, grant_i, grant_d;
  logic rd_strobe, wr_strobe, rd_hit, wr_hit, wd_fire;
  logic i_fill_done, d_fill_done, wb_only_done, d_nop;

  always_comb begin
    // A requester still showing its done pulse may not have dropped req yet.
    i_elig       = bus.i_req && !i_done_q;
    d_elig       = bus.d_req && !d_done_q;
    grant_i      = 1'b0;
    grant_d      = 1'b0;
    if (state == IDLE) begin
      if (i_elig && d_elig) begin
        grant_d = !last_served_d;
        grant_i = last_served_d;
      end else begin
        grant_i = i_elig;
        grant_d = d_elig;
      end
    end

    rd_strobe    = ((state == IRD) || (state == DRD)) && !wd_drop;
    wr_strobe    = (state == DWB) && !wd_drop;
    rd_hit       = rd_strobe && bus.mem_read_valid;
    wr_hit       = wr_strobe && bus.mem_write_valid;
    wd_fire      = ((rd_strobe && !rd_hit) || (wr_strobe && !wr_hit)) &&
                   (wd_cnt == CW'(TIMEOUT - 1));

    i_fill_done  = (state == IRD) && rd_hit;
    d_fill_done  = (state == DRD) && rd_hit;
    wb_only_done = wr_hit && !d_rd_q;
    d_nop        = grant_d && !bus.d_wb && !bus.d_rd;

    state_n = state;
    case (state)
      IDLE: begin
        if (grant_i)                   state_n = IRD;
        else if (grant_d && bus.d_wb)  state_n = DWB;
        else if (grant_d && bus.d_rd)  state_n = DRD;
      end
      IRD, DRD: if (rd_hit) state_n = IDLE;
      DWB:      if (wr_hit) state_n = d_rd_q ? DRD : IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state         <= IDLE;
      last_served_d <= 1'b0;
      wd_cnt        <= '0;
      wd_drop       <= 1'b0;
      timeout_err_q <= 1'b0;
      i_addr_q      <= '0;
      d_wb_addr_q   <= '0;
      d_addr_q      <= '0;
      d_rd_q        <= 1'b0;
      d_wdata_q     <= '0;
      i_data_q      <= '0;
      d_rdata_q     <= '0;
      i_done_q      <= 1'b0;
      d_done_q      <= 1'b0;
    end else begin
      state    <= state_n;
      i_done_q <= i_fill_done;
      d_done_q <= d_fill_done || wb_only_done || d_nop;

      if (grant_i) i_addr_q <= bus.i_addr;
      if (grant_d) begin
        d_wb_addr_q <= bus.d_wb_addr;
        d_addr_q    <= bus.d_addr;
        d_rd_q      <= bus.d_rd;
        d_wdata_q   <= bus.d_wdata;
      end

      if (i_fill_done) i_data_q  <= bus.mem_rdata;
      if (d_fill_done) d_rdata_q <= bus.mem_rdata;

      if (i_fill_done)                                 last_served_d <= 1'b0;
      else if (d_fill_done || wb_only_done || d_nop)   last_served_d <= 1'b1;

      // Retry drops the strobe for one cycle; address and data registers stay put.
      if (state_n != state) begin
        wd_cnt  <= '0;
        wd_drop <= 1'b0;
      end else if (wd_fire) begin
        wd_cnt        <= '0;
        wd_drop       <= 1'b1;
        timeout_err_q <= 1'b1;
      end else if (rd_strobe || wr_strobe) begin
        wd_cnt  <= wd_cnt + 1'b1;
        wd_drop <= 1'b0;
      end else begin
        wd_drop <= 1'b0;
      end
    end
  end

  always_comb begin
    case (state)
      IRD:     bus.mem_addr = i_addr_q & BLK_MASK;
      DWB:     bus.mem_addr = d_wb_addr_q & BLK_MASK;
      DRD:     bus.mem_addr = d_addr_q & BLK_MASK;
      default: bus.mem_addr = '0;
    endcase
  end

  assign bus.mem_blk_read  = rd_strobe;
  assign bus.mem_blk_write = wr_strobe;
  assign bus.mem_wdata     = (state == DWB) ? d_wdata_q : '0;
  assign bus.i_data        = i_data_q;
  assign bus.d_rdata       = d_rdata_q;
  assign bus.i_done        = i_done_q;
  assign bus.d_done        = d_done_q;
  assign bus.busy          = (state != IDLE);
  assign bus.timeout_err   = timeout_err_q;
  assign dbg_state         = state;

endmodule

// File: tb/tb_mem_blk_arbiter.sv
// Bench for mem_blk_arbiter: directed scenarios plus randomized rounds scored against
// a round-robin transaction model of the block port.
module tb_mem_blk_arbiter;
  localparam int BLK_W   = 256;
  localparam int TIMEOUT = 8;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic [1:0] dbg_state;
  int         tests_run = 0;
  int         tests_failed = 0;

  mem_blk_arbiter_if #(.BLK_W(BLK_W)) bus ();

  mem_blk_arbiter #(.BLK_W(BLK_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // ---------------- memory responder state ----------------
  int               resp_delay = 1;
  int               resp_age = 0;
  bit               resp_rand = 0;
  bit               valid_fired = 0;
  logic [BLK_W-1:0] last_rdata = '0;

  // ---------------- reference model (transaction level) ----------------
  logic [33:0]      exp_q[$];      // {kind: 1=I read, 2=D write, 3=D read, block address}
  logic [BLK_W-1:0] exp_wd_q[$];
  logic             exp_done_q[$]; // 0 = I done, 1 = D done
  logic             model_last_d = 1'b0;

  function automatic logic [BLK_W-1:0] rand_blk();
    logic [BLK_W-1:0] r;
    for (int w = 0; w < BLK_W / 32; w++) r[w*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic void model_serve_i();
    exp_q.push_back({2'd1, bus.i_addr[31:5], 5'b0});
    exp_done_q.push_back(1'b0);
    model_last_d = 1'b0;
  endfunction

  function automatic void model_serve_d();
    if (bus.d_wb) begin
      exp_q.push_back({2'd2, bus.d_wb_addr[31:5], 5'b0});
      exp_wd_q.push_back(bus.d_wdata);
    end
    if (bus.d_rd) exp_q.push_back({2'd3, bus.d_addr[31:5], 5'b0});
    exp_done_q.push_back(1'b1);
    model_last_d = 1'b1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    bus.i_req = 1'b0;  bus.i_addr = '0;
    bus.d_req = 1'b0;  bus.d_wb = 1'b0;  bus.d_rd = 1'b0;
    bus.d_wb_addr = '0; bus.d_wdata = '0; bus.d_addr = '0;
    bus.mem_rdata = '0; bus.mem_read_valid = 1'b0; bus.mem_write_valid = 1'b0;
  endtask

  task automatic do_reset();
    cyc();
    RESET = 1'b0;
    idle_inputs();
    resp_age = 0;
    valid_fired = 0;
    cyc();
    cyc();
    RESET = 1'b1;
  endtask

  // Answers the active strobe once it has been up for resp_delay cycles.
  task automatic mem_tick();
    bus.mem_read_valid  = 1'b0;
    bus.mem_write_valid = 1'b0;
    valid_fired = 0;
    if (bus.mem_blk_read || bus.mem_blk_write) begin
      if (resp_age >= resp_delay) begin
        bus.mem_read_valid  = bus.mem_blk_read;
        bus.mem_write_valid = bus.mem_blk_write;
        bus.mem_rdata = rand_blk();
        last_rdata = bus.mem_rdata;
        valid_fired = 1;
        resp_age = 0;
        if (resp_rand) resp_delay = $urandom_range(0, 4);
      end else begin
        resp_age++;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    cyc();
    RESET = 1'b0;
    idle_inputs();
    cyc();
    cyc();
    tests_run++;
    if ({bus.mem_blk_read, bus.mem_blk_write, bus.i_done, bus.d_done, bus.busy, bus.timeout_err} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b exp 000000", {bus.mem_blk_read, bus.mem_blk_write, bus.i_done, bus.d_done, bus.busy, bus.timeout_err});
    end
    tests_run++;
    if ({bus.mem_addr, bus.mem_wdata, bus.i_data, bus.d_rdata} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: addr %h wdata %h i_data %h d_rdata %h exp all 0", bus.mem_addr, bus.mem_wdata, bus.i_data, bus.d_rdata);
    end
    RESET = 1'b1;
    cyc();
    tests_run++;
    if (dbg_state !== 2'd0 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle: state %0d busy %b exp 0 0", dbg_state, bus.busy);
    end
  endtask

  task automatic test_i_read();
    logic [BLK_W-1:0] pat;
    logic [BLK_W-1:0] got;
    logic [31:0]      addr_k1;
    int hi, done_cnt, done_k;
    pat = {(BLK_W/8){8'hA5}};
    hi = 0; done_cnt = 0; done_k = -1; addr_k1 = 'x; got = 'x;
    do_reset();
    bus.i_addr = 32'h0040_0024;
    bus.i_req = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      if (bus.mem_blk_read) hi++;
      if (k == 1) addr_k1 = bus.mem_blk_read ? bus.mem_addr : 32'hDEAD_BEEF;
      if (bus.i_done) begin
        done_cnt++; done_k = k; got = bus.i_data; bus.i_req = 1'b0;
      end
      bus.mem_read_valid = (k == 4);
      bus.mem_rdata = pat;
    end
    tests_run++;
    if (addr_k1 !== 32'h0040_0020) begin
      tests_failed++; $display("FAIL iread_addr: got %h exp 00400020", addr_k1);
    end
    tests_run++;
    if (hi !== 4) begin
      tests_failed++; $display("FAIL iread_strobe_len: got %0d exp 4", hi);
    end
    tests_run++;
    if (done_cnt !== 1 || done_k !== 5) begin
      tests_failed++; $display("FAIL iread_done: count %0d cycle %0d exp 1 at 5", done_cnt, done_k);
    end
    tests_run++;
    if (got !== pat || bus.i_data !== pat) begin
      tests_failed++; $display("FAIL iread_data: got %h exp %h", got, pat);
    end
  endtask

  task automatic test_tie();
    logic [31:0] first_addr;
    int first_k, d_done_k, i_rise_k;
    bit done_all;
    first_addr = 'x; first_k = -1; d_done_k = -1; i_rise_k = -1; done_all = 0;
    do_reset();
    resp_rand = 0; resp_delay = 1;
    bus.i_addr = 32'h0000_1104; bus.i_req = 1'b1;
    bus.d_addr = 32'h0000_2208; bus.d_rd = 1'b1; bus.d_wb = 1'b0; bus.d_req = 1'b1;
    for (int k = 1; k <= 40 && !done_all; k++) begin
      cyc();
      if ((bus.mem_blk_read || bus.mem_blk_write) && first_k < 0) begin
        first_k = k; first_addr = bus.mem_addr;
      end
      if (bus.mem_blk_read && bus.mem_addr == 32'h0000_1100 && i_rise_k < 0) i_rise_k = k;
      if (bus.d_done) begin d_done_k = k; bus.d_req = 1'b0; end
      if (bus.i_done) begin bus.i_req = 1'b0; done_all = 1; end
      mem_tick();
    end
    tests_run++;
    if (first_addr !== 32'h0000_2200 || first_k !== 1) begin
      tests_failed++; $display("FAIL tie_first: addr %h cycle %0d exp 00002200 at 1", first_addr, first_k);
    end
    tests_run++;
    if (!done_all || d_done_k < 0 || i_rise_k !== d_done_k + 1) begin
      tests_failed++; $display("FAIL tie_second: i strobe cycle %0d d_done cycle %0d done %0d", i_rise_k, d_done_k, done_all);
    end
  endtask

  task automatic test_fairness();
    int  order[6];
    int  rise[6];
    int  n;
    bit  prev, i_rearm, d_rearm;
    n = 0; prev = 0; i_rearm = 0; d_rearm = 0;
    do_reset();
    resp_rand = 0; resp_delay = 1;
    bus.i_addr = 32'h0000_0100; bus.d_addr = 32'h0000_0200;
    bus.d_rd = 1'b1; bus.d_wb = 1'b0;
    bus.i_req = 1'b1; bus.d_req = 1'b1;
    for (int k = 1; k <= 200 && n < 6; k++) begin
      cyc();
      if (bus.mem_blk_read && !prev) begin
        order[n] = (bus.mem_addr == 32'h0000_0100) ? 0 : 1;
        rise[n] = k;
        n++;
      end
      prev = bus.mem_blk_read;
      if (i_rearm) begin bus.i_req = 1'b1; i_rearm = 0; end
      if (d_rearm) begin bus.d_req = 1'b1; d_rearm = 0; end
      if (bus.i_done) begin bus.i_req = 1'b0; i_rearm = 1; end
      if (bus.d_done) begin bus.d_req = 1'b0; d_rearm = 1; end
      mem_tick();
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    tests_run++;
    if (n !== 6) begin
      tests_failed++; $display("FAIL fair_count: got %0d grants exp 6", n);
    end else begin
      for (int j = 0; j < 6; j++) begin
        tests_run++;
        if (order[j] !== ((j % 2 == 0) ? 1 : 0)) begin
          tests_failed++; $display("FAIL fair_order[%0d]: got %s exp %s", j, order[j] ? "D" : "I", (j % 2 == 0) ? "D" : "I");
        end
        if (j > 0) begin
          tests_run++;
          if (rise[j] - rise[j-1] !== 3) begin
            tests_failed++; $display("FAIL fair_gap[%0d]: got %0d cycles exp 3", j, rise[j] - rise[j-1]);
          end
        end
      end
    end
  endtask

  task automatic test_dirty_evict();
    logic [BLK_W-1:0] wd, wr_data, got_rd, exp_rd;
    logic [31:0] wr_addr, rd_addr;
    int wr_k, wr_valid_k, rd_k, dd, id, both;
    wr_k = -1; wr_valid_k = -1; rd_k = -1; dd = 0; id = 0; both = 0;
    wr_addr = 'x; rd_addr = 'x; wr_data = 'x; got_rd = 'x; exp_rd = 'x;
    do_reset();
    resp_rand = 0; resp_delay = 2;
    wd = rand_blk();
    bus.d_wb = 1'b1; bus.d_rd = 1'b1;
    bus.d_wb_addr = 32'h1000_1040; bus.d_addr = 32'h1000_2040; bus.d_wdata = wd;
    bus.d_req = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      if (bus.mem_blk_read && bus.mem_blk_write) both++;
      if (bus.mem_blk_write && wr_k < 0) begin wr_k = k; wr_addr = bus.mem_addr; wr_data = bus.mem_wdata; end
      if (bus.mem_blk_read && rd_k < 0) begin rd_k = k; rd_addr = bus.mem_addr; end
      if (bus.d_done) begin dd++; got_rd = bus.d_rdata; bus.d_req = 1'b0; end
      if (bus.i_done) id++;
      mem_tick();
      if (valid_fired && bus.mem_write_valid) wr_valid_k = k;
      if (valid_fired && bus.mem_read_valid) exp_rd = last_rdata;
    end
    tests_run++;
    if (wr_addr !== 32'h1000_1040 || wr_k !== 1 || wr_data !== wd) begin
      tests_failed++; $display("FAIL evict_write: addr %h cycle %0d data %h exp 10001040 at 1 data %h", wr_addr, wr_k, wr_data, wd);
    end
    tests_run++;
    if (rd_addr !== 32'h1000_2040 || wr_valid_k < 0 || rd_k !== wr_valid_k + 1) begin
      tests_failed++; $display("FAIL evict_read: addr %h cycle %0d exp 10002040 at %0d", rd_addr, rd_k, wr_valid_k + 1);
    end
    tests_run++;
    if (dd !== 1 || id !== 0 || both !== 0) begin
      tests_failed++; $display("FAIL evict_dones: d_done %0d i_done %0d overlap %0d exp 1 0 0", dd, id, both);
    end
    tests_run++;
    if (got_rd !== exp_rd) begin
      tests_failed++; $display("FAIL evict_rdata: got %h exp %h", got_rd, exp_rd);
    end
  endtask

  task automatic test_watchdog();
    logic [15:0] strobe_v, err_v, done_v, exp_strobe, exp_err, exp_done;
    logic [BLK_W-1:0] rd;
    strobe_v = '0; err_v = '0; done_v = '0;
    exp_strobe = '0; exp_err = '0; exp_done = '0;
    for (int k = 1; k <= 16; k++) begin
      exp_strobe[k-1] = (k <= TIMEOUT) || (k >= TIMEOUT + 2 && k <= 12);
      exp_err[k-1]    = (k >= TIMEOUT + 1);
      exp_done[k-1]   = (k == 13);
    end
    rd = rand_blk();
    do_reset();
    bus.i_addr = 32'h3000_0010;
    bus.i_req = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      cyc();
      strobe_v[k-1] = bus.mem_blk_read;
      err_v[k-1]    = bus.timeout_err;
      done_v[k-1]   = bus.i_done;
      if (bus.i_done) bus.i_req = 1'b0;
      bus.mem_read_valid = (k == 12);
      bus.mem_rdata = rd;
    end
    bus.mem_read_valid = 1'b0;
    tests_run++;
    if (strobe_v !== exp_strobe) begin
      tests_failed++; $display("FAIL wd_strobe: got %b exp %b", strobe_v, exp_strobe);
    end
    tests_run++;
    if (err_v !== exp_err) begin
      tests_failed++; $display("FAIL wd_err: got %b exp %b", err_v, exp_err);
    end
    tests_run++;
    if (done_v !== exp_done || bus.i_data !== rd) begin
      tests_failed++; $display("FAIL wd_done: got %b data %h exp %b data %h", done_v, bus.i_data, exp_done, rd);
    end
  endtask

  task automatic test_reset_mid_op();
    int bad;
    bad = 0;
    cyc();
    bus.d_wb = 1'b1; bus.d_rd = 1'b1;
    bus.d_wb_addr = 32'h2000_0040; bus.d_addr = 32'h2000_0080; bus.d_wdata = rand_blk();
    bus.d_req = 1'b1;
    cyc();
    tests_run++;
    if (bus.mem_blk_write !== 1'b1 || bus.mem_addr !== 32'h2000_0040) begin
      tests_failed++; $display("FAIL midrst_dwb: write %b addr %h exp 1 20000040", bus.mem_blk_write, bus.mem_addr);
    end
    cyc();
    RESET = 1'b0;
    bus.d_req = 1'b0;
    cyc();
    tests_run++;
    if ({bus.mem_blk_read, bus.mem_blk_write, bus.i_done, bus.d_done, bus.busy, bus.timeout_err} !== 6'b0 ||
        dbg_state !== 2'd0) begin
      tests_failed++;
      $display("FAIL midrst_ctrl: got %b state %0d exp 000000 0", {bus.mem_blk_read, bus.mem_blk_write, bus.i_done, bus.d_done, bus.busy, bus.timeout_err}, dbg_state);
    end
    tests_run++;
    if ({bus.mem_addr, bus.mem_wdata, bus.i_data, bus.d_rdata} !== '0) begin
      tests_failed++;
      $display("FAIL midrst_data: addr %h wdata %h i_data %h d_rdata %h exp all 0", bus.mem_addr, bus.mem_wdata, bus.i_data, bus.d_rdata);
    end
    RESET = 1'b1;
    bus.mem_write_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      bus.mem_write_valid = 1'b0;
      if (bus.d_done || bus.i_done || bus.busy || bus.mem_blk_read || bus.mem_blk_write) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++; $display("FAIL midrst_after: got %0d active cycles exp 0", bad);
    end
  endtask

  task automatic test_random(input int rounds);
    logic [33:0]      cur;
    logic [1:0]       cur_kind;
    logic [BLK_W-1:0] wd, exp_i_data, exp_d_data;
    logic             exp_side;
    bit               want_i, want_d, op_active;
    int               remaining, overlap;
    do_reset();
    resp_rand = 1; resp_delay = $urandom_range(0, 4);
    exp_q.delete(); exp_wd_q.delete(); exp_done_q.delete();
    model_last_d = 1'b0;
    exp_i_data = '0; exp_d_data = '0; cur_kind = 2'd0; overlap = 0;
    for (int r = 0; r < rounds; r++) begin
      cyc();
      want_i = ($urandom_range(0, 1) == 1);
      want_d = ($urandom_range(0, 1) == 1);
      if (!want_i && !want_d) want_i = 1;
      bus.i_addr = $urandom(); bus.d_wb_addr = $urandom(); bus.d_addr = $urandom();
      bus.d_wb = ($urandom_range(0, 1) == 1); bus.d_rd = ($urandom_range(0, 1) == 1);
      bus.d_wdata = rand_blk();
      // Round-robin: on a tie the side not served last goes first.
      if (want_i && want_d) begin
        if (model_last_d) begin model_serve_i(); model_serve_d(); end
        else begin model_serve_d(); model_serve_i(); end
      end else if (want_i) model_serve_i();
      else model_serve_d();
      bus.i_req = want_i; bus.d_req = want_d;
      remaining = int'(want_i) + int'(want_d);
      op_active = 0;
      for (int k = 0; k < 100 && remaining > 0; k++) begin
        cyc();
        if (bus.mem_blk_read && bus.mem_blk_write) overlap++;
        if ((bus.mem_blk_read || bus.mem_blk_write) && !op_active) begin
          op_active = 1;
          tests_run++;
          if (exp_q.size() == 0) begin
            tests_failed++; $display("FAIL rnd_extra_op: addr %h exp no transfer", bus.mem_addr);
          end else begin
            cur = exp_q.pop_front();
            cur_kind = cur[33:32];
            if ({bus.mem_blk_write, bus.mem_addr} !== {cur_kind == 2'd2, cur[31:0]}) begin
              tests_failed++; $display("FAIL rnd_op: got wr=%b addr %h exp wr=%b addr %h", bus.mem_blk_write, bus.mem_addr, cur_kind == 2'd2, cur[31:0]);
            end
            if (cur_kind == 2'd2) begin
              wd = exp_wd_q.pop_front();
              tests_run++;
              if (bus.mem_wdata !== wd) begin
                tests_failed++; $display("FAIL rnd_wdata: got %h exp %h", bus.mem_wdata, wd);
              end
            end
          end
        end
        if (bus.i_done || bus.d_done) begin
          tests_run++;
          if (exp_done_q.size() == 0) begin
            tests_failed++; $display("FAIL rnd_extra_done: got i=%b d=%b exp none", bus.i_done, bus.d_done);
          end else begin
            exp_side = exp_done_q.pop_front();
            if ({bus.i_done, bus.d_done} !== (exp_side ? 2'b01 : 2'b10)) begin
              tests_failed++; $display("FAIL rnd_done_side: got i=%b d=%b exp %s", bus.i_done, bus.d_done, exp_side ? "D" : "I");
            end
            tests_run++;
            if (exp_side ? (bus.d_rdata !== exp_d_data) : (bus.i_data !== exp_i_data)) begin
              tests_failed++; $display("FAIL rnd_data: got %h exp %h", exp_side ? bus.d_rdata : bus.i_data, exp_side ? exp_d_data : exp_i_data);
            end
          end
          if (bus.i_done) bus.i_req = 1'b0;
          if (bus.d_done) bus.d_req = 1'b0;
          remaining--;
        end
        mem_tick();
        if (valid_fired) begin
          op_active = 0;
          if (bus.mem_read_valid) begin
            if (cur_kind == 2'd1) exp_i_data = last_rdata;
            else exp_d_data = last_rdata;
          end
        end
      end
      tests_run++;
      if (remaining != 0 || exp_q.size() != 0 || exp_done_q.size() != 0) begin
        tests_failed++; $display("FAIL rnd_drain[%0d]: got %0d pending dones %0d ops exp 0 0", r, remaining, exp_q.size());
        bus.i_req = 1'b0; bus.d_req = 1'b0;
      end
    end
    tests_run++;
    if (overlap !== 0) begin
      tests_failed++; $display("FAIL rnd_strobe_excl: got %0d overlap cycles exp 0", overlap);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_inputs();
    test_reset();
    test_i_read();
    test_tie();
    test_fairness();
    test_dirty_evict();
    test_random(24);
    test_watchdog();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
